wb_write_queue: RTL



---
 rtl/wb_write_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: merges ALU and memory write-back requests into one
// registered register-file write stream through a small FIFO.
// Optional feature macro WBQ_BYPASS_EN: an accepted request skips an empty FIFO.
module wb_write_queue #(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [N-1:0]      mem_wa,
    input  logic [W-1:0]      mem_wd,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [N-1:0]      alu_wa,
    input  logic [W-1:0]      alu_wd,
    output logic              alu_ready,
    output logic              regWrite,
    output logic [N-1:0]      WA,
    output logic [W-1:0]      WD,
    output logic [(1<<N)-1:0] pending,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  wa_mem [DEPTH];
    logic [W-1:0]  wd_mem [DEPTH];

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [N-1:0]  wa_q, wa_d;
    logic [W-1:0]  wd_q, wd_d;

    logic          not_full;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          fifo_push;
    logic [N-1:0]  push_wa;
    logic [W-1:0]  push_wd;

    // Space is judged on the registered count only; a same-edge pop
    // never frees a slot early. Memory path wins as it is older.
    assign not_full  = !rst && (cnt_q < CW'(DEPTH));
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;

    assign push    = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_wa = mem_valid ? mem_wa : alu_wa;
    assign push_wd = mem_valid ? mem_wd : alu_wd;
    assign pop     = (cnt_q != '0);

`ifdef WBQ_BYPASS_EN
    assign bypass = push && !pop;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = push && !bypass;

    // Next state: pop the head onto the write port, or bypass, else idle.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        rw_d  = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (pop) begin
            rw_d = 1'b1;
            wa_d = wa_mem[rd_q];
            wd_d = wd_mem[rd_q];
            rd_d = rd_q + AW'(1);
        end else if (bypass) begin
            rw_d = 1'b1;
            wa_d = push_wa;
            wd_d = push_wd;
        end
        if (fifo_push) begin
            wr_d = wr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(fifo_push) - CW'(pop);
    end

    // Control and output registers; reset drops any queued writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rw_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rw_q  <= rw_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
        end
    end

    // FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            wa_mem[wr_q] <= push_wa;
            wd_mem[wr_q] <= push_wd;
        end
    end

    // Pending mask: every occupied entry, not the one on the write port.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q) begin
                pending[wa_mem[rd_q + AW'(i)]] = 1'b1;
            end
        end
    end

    assign regWrite = rw_q;
    assign WA       = wa_q;
    assign WD       = wd_q;
    assign busy     = (cnt_q != '0) || rw_q;

endmodule
